// File: rtl/wb_tracker.sv
// Writeback/memory-response tracker: buffers EX trace elements, timestamps their
// writeback phase (and memory response for loads/stores), and streams finished
// elements to the trace sink over valid/ready.

package wb_tracker_pkg;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } ts_t;

  typedef struct packed {
    logic        pass_through;
    logic [31:0] pc;
    logic [31:0] insn;
    ts_t         mem_access_res;
    ts_t         wb_data;
  } trace_output;

  localparam int unsigned TRACE_W = $bits(trace_output);

endpackage

module wb_tracker
  import wb_tracker_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RVALID_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        counter,
  input  logic               ex_data_ready,
  input  logic [TRACE_W-1:0] ex_data_i,
  input  logic               data_gnt_i,
  input  logic               data_rvalid_i,
  input  logic               trace_ready_i,
  output logic               trace_valid_o,
  output logic [TRACE_W-1:0] trace_data_o,
  output logic               overflow_o
);

  localparam int unsigned EAW = $clog2(FIFO_DEPTH);
  localparam int unsigned RAW = $clog2(RVALID_DEPTH);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_RSP,
    WB_EMIT
  } wb_state_e;

  // Element FIFO: trace element plus "memory access" flag captured at push.
  trace_output  e_data [FIFO_DEPTH];
  logic         e_mem  [FIFO_DEPTH];
  logic [EAW:0] e_wr;
  logic [EAW:0] e_rd;
  logic         e_empty;
  logic         e_full;
  logic         e_push;
  logic         e_pop;
  trace_output  e_head;
  logic         e_head_mem;

  // Response FIFO: counter value at each data_rvalid_i.
  logic [31:0]  r_data [RVALID_DEPTH];
  logic [RAW:0] r_wr;
  logic [RAW:0] r_rd;
  logic         r_empty;
  logic         r_full;
  logic         r_push;
  logic         r_pop;
  logic [31:0]  r_head;

  wb_state_e    state;
  wb_state_e    state_nxt;
  trace_output  wb_q;
  trace_output  wb_nxt;
  logic         valid_q;
  logic         overflow_q;

  // FIFO status and head decode; a push on a full FIFO is accepted only with a same-cycle pop.
  always_comb begin
    e_empty    = (e_wr == e_rd);
    e_full     = (e_wr[EAW] != e_rd[EAW]) && (e_wr[EAW-1:0] == e_rd[EAW-1:0]);
    e_push     = ex_data_ready && (!e_full || e_pop);
    e_head     = e_data[e_rd[EAW-1:0]];
    e_head_mem = e_mem[e_rd[EAW-1:0]];
    r_empty    = (r_wr == r_rd);
    r_full     = (r_wr[RAW] != r_rd[RAW]) && (r_wr[RAW-1:0] == r_rd[RAW-1:0]);
    r_push     = data_rvalid_i && (!r_full || r_pop);
    r_head     = r_data[r_rd[RAW-1:0]];
  end

  // FIFO storage writes (contents need no reset; pointers define validity).
  always_ff @(posedge clk) begin
    if (e_push) begin
      e_data[e_wr[EAW-1:0]] <= ex_data_i;
      e_mem[e_wr[EAW-1:0]]  <= data_gnt_i;
    end
    if (r_push) begin
      r_data[r_wr[RAW-1:0]] <= counter;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_wr       <= '0;
      e_rd       <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (e_push) e_wr <= e_wr + 1'b1;
      if (e_pop)  e_rd <= e_rd + 1'b1;
      if (r_push) r_wr <= r_wr + 1'b1;
      if (r_pop)  r_rd <= r_rd + 1'b1;
      if ((ex_data_ready && !e_push) || (data_rvalid_i && !r_push)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, FIFO pops and working-register update.
  always_comb begin
    state_nxt = state;
    e_pop     = 1'b0;
    r_pop     = 1'b0;
    wb_nxt    = wb_q;
    case (state)
      WB_IDLE: begin
        if (!e_empty) begin
          e_pop  = 1'b1;
          wb_nxt = e_head;
          if (e_head.pass_through) begin
            state_nxt = WB_EMIT;
          end else begin
            wb_nxt.wb_data.time_start = counter;
            if (e_head_mem) begin
              wb_nxt.mem_access_res.time_start = counter;
              state_nxt = WB_WAIT_RSP;
            end else begin
              wb_nxt.wb_data.time_end = counter;
              state_nxt = WB_EMIT;
            end
          end
        end
      end
      WB_WAIT_RSP: begin
        if (!r_empty) begin
          r_pop = 1'b1;
          wb_nxt.mem_access_res.time_end = r_head;
          // A response queued before the pop can predate time_start; clamp to it.
          wb_nxt.wb_data.time_end = (r_head > wb_q.wb_data.time_start) ?
                                    r_head : wb_q.wb_data.time_start;
          state_nxt = WB_EMIT;
        end
      end
      WB_EMIT: begin
        if (trace_ready_i) state_nxt = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  // Working register and registered valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      wb_q    <= wb_nxt;
      valid_q <= (state_nxt == WB_EMIT);
    end
  end

  // Outputs driven straight from flops.
  always_comb begin
    trace_valid_o = valid_q;
    trace_data_o  = wb_q;
    overflow_o    = overflow_q;
  end

endmodule
